// File: rtl/taxi_baser_pkg.sv
// Shared BASE-R definitions used by the encoder, the decoder and the
// receive block-lock FSM.
//
// Contents:
//   SYNC_DATA    - sync header that marks a 64-bit data block
//   SYNC_CTRL    - sync header that marks a block carrying control characters
//   sync_hdr_ok  - true for the two legal sync header values
package taxi_baser_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    // 2'b00 and 2'b11 never appear on a correctly aligned link.
    function automatic logic sync_hdr_ok(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/taxi_baser_rx_block_lock.sv
// BASE-R receive block lock.
//
// Watches the sync headers coming out of the gearbox in windows of 64
// sampled headers. Sixty-four clean headers in a row declare lock. While
// locked, up to 15 bad headers per window are tolerated; the 16th bad
// header, or any bad header while unlocked, drops lock and asks the
// SERDES/gearbox to slip alignment by one bit. After the slip pulse the
// block waits for alignment to settle before testing headers again.
//
// Parameters:
//   HDR_W                - sync header width, must be 2
//   BITSLIP_HIGH_CYCLES  - clocks serdes_rx_bitslip is held high per slip
//   BITSLIP_LOW_CYCLES   - clocks to wait after the slip pulse
//
// Ports:
//   clk                  - clock, rising edge
//   rst                  - asynchronous reset, active high
//   encoded_rx_hdr       - sync header from the gearbox
//   encoded_rx_hdr_valid - header is sampled only when high
//   serdes_rx_bitslip    - registered bit-slip request
//   rx_block_lock        - registered block-lock status
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_TEST      | counting sampled headers in the current 64-header window
// ST_SLIP_HIGH | bit-slip request asserted, headers ignored
// ST_SLIP_WAIT | bit-slip request released, waiting for alignment to settle
module taxi_baser_rx_block_lock #(
    parameter int HDR_W               = 2,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [HDR_W-1:0] encoded_rx_hdr,
    input  logic             encoded_rx_hdr_valid,
    output logic             serdes_rx_bitslip,
    output logic             rx_block_lock
);

    import taxi_baser_pkg::*;

    if (HDR_W != 2) begin : g_bad_hdr_w
        $fatal(1, "HDR_W must be 2");
    end
    if (BITSLIP_HIGH_CYCLES < 1) begin : g_bad_slip_high
        $fatal(1, "BITSLIP_HIGH_CYCLES must be at least 1");
    end
    if (BITSLIP_LOW_CYCLES < 1) begin : g_bad_slip_low
        $fatal(1, "BITSLIP_LOW_CYCLES must be at least 1");
    end

    localparam int SLIP_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                              BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
    localparam int SLIP_W   = $clog2(SLIP_MAX + 1);

    localparam logic [SLIP_W-1:0] SLIP_HIGH_LOAD = SLIP_W'(BITSLIP_HIGH_CYCLES);
    localparam logic [SLIP_W-1:0] SLIP_LOW_LOAD  = SLIP_W'(BITSLIP_LOW_CYCLES);
    localparam logic [SLIP_W-1:0] SLIP_ONE       = SLIP_W'(1);

    typedef enum logic [1:0] {
        ST_TEST,
        ST_SLIP_HIGH,
        ST_SLIP_WAIT
    } state_t;

    state_t            state, state_next;
    logic [6:0]        sh_cnt, sh_cnt_next;
    logic [4:0]        sh_invalid_cnt, sh_invalid_cnt_next;
    logic [SLIP_W-1:0] slip_cnt, slip_cnt_next;
    logic              bitslip_next;
    logic              lock_next;
    logic              hdr_ok;

    assign hdr_ok = sync_hdr_ok(encoded_rx_hdr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_TEST;
            sh_cnt            <= '0;
            sh_invalid_cnt    <= '0;
            slip_cnt          <= '0;
            serdes_rx_bitslip <= 1'b0;
            rx_block_lock     <= 1'b0;
        end else begin
            state             <= state_next;
            sh_cnt            <= sh_cnt_next;
            sh_invalid_cnt    <= sh_invalid_cnt_next;
            slip_cnt          <= slip_cnt_next;
            serdes_rx_bitslip <= bitslip_next;
            rx_block_lock     <= lock_next;
        end
    end

    always_comb begin
        state_next          = state;
        sh_cnt_next         = sh_cnt;
        sh_invalid_cnt_next = sh_invalid_cnt;
        slip_cnt_next       = slip_cnt;
        bitslip_next        = serdes_rx_bitslip;
        lock_next           = rx_block_lock;

        case (state)
            ST_TEST: begin
                if (encoded_rx_hdr_valid) begin
                    sh_cnt_next = sh_cnt + 7'd1;
                    if (!hdr_ok) begin
                        sh_invalid_cnt_next = sh_invalid_cnt + 5'd1;
                    end

                    // A bad header while unlocked, or the 16th bad header of
                    // a window, means we are misaligned: slip one bit.
                    if (!hdr_ok && (!rx_block_lock || sh_invalid_cnt == 5'd15)) begin
                        state_next          = ST_SLIP_HIGH;
                        lock_next           = 1'b0;
                        bitslip_next        = 1'b1;
                        sh_cnt_next         = '0;
                        sh_invalid_cnt_next = '0;
                        slip_cnt_next       = SLIP_HIGH_LOAD;
                    end else if (sh_cnt == 7'd63) begin
                        // End of window. Only a fully clean window grants
                        // lock; a window with tolerated errors keeps it.
                        if (hdr_ok && sh_invalid_cnt == 5'd0) begin
                            lock_next = 1'b1;
                        end
                        sh_cnt_next         = '0;
                        sh_invalid_cnt_next = '0;
                    end
                end
            end

            ST_SLIP_HIGH: begin
                if (slip_cnt <= SLIP_ONE) begin
                    state_next    = ST_SLIP_WAIT;
                    bitslip_next  = 1'b0;
                    slip_cnt_next = SLIP_LOW_LOAD;
                end else begin
                    slip_cnt_next = slip_cnt - SLIP_ONE;
                end
            end

            ST_SLIP_WAIT: begin
                if (slip_cnt <= SLIP_ONE) begin
                    state_next    = ST_TEST;
                    slip_cnt_next = '0;
                end else begin
                    slip_cnt_next = slip_cnt - SLIP_ONE;
                end
            end

            default: begin
                state_next          = ST_TEST;
                sh_cnt_next         = '0;
                sh_invalid_cnt_next = '0;
                slip_cnt_next       = '0;
                bitslip_next        = 1'b0;
                lock_next           = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_taxi_baser_rx_block_lock.sv
// Bench for taxi_baser_rx_block_lock. Two instances share the header inputs:
// dut0 with default slip timing (1 high, 8 low) and dut4 with a 4-cycle slip
// pulse. Each has its own reset. A window/slip-budget model predicts both
// outputs of both instances after every clock.
module tb_taxi_baser_rx_block_lock;

    localparam int LOW_CYC = 8;

    logic       clk = 1'b0;
    logic       rst0, rst1;
    logic [1:0] hdr;
    logic       hv;
    logic       slip0, lock0, slip1, lock1;

    int n_vec  = 0;
    int n_fail = 0;

    // Model: headers seen / bad headers in window, lock flag, and the number
    // of remaining clocks during which headers are ignored after a slip.
    int m_n[2];
    int m_bad[2];
    int m_busy[2];
    bit m_lock[2];
    int m_high[2];

    always #5 clk = ~clk;

    taxi_baser_rx_block_lock dut0 (
        .clk                  (clk),
        .rst                  (rst0),
        .encoded_rx_hdr       (hdr),
        .encoded_rx_hdr_valid (hv),
        .serdes_rx_bitslip    (slip0),
        .rx_block_lock        (lock0)
    );

    taxi_baser_rx_block_lock #(
        .HDR_W               (2),
        .BITSLIP_HIGH_CYCLES (4),
        .BITSLIP_LOW_CYCLES  (8)
    ) dut4 (
        .clk                  (clk),
        .rst                  (rst1),
        .encoded_rx_hdr       (hdr),
        .encoded_rx_hdr_valid (hv),
        .serdes_rx_bitslip    (slip1),
        .rx_block_lock        (lock1)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_n[i]    = 0;
        m_bad[i]  = 0;
        m_busy[i] = 0;
        m_lock[i] = 1'b0;
    endtask

    task automatic model_step(input int i, input logic [1:0] h, input logic v, input logic r);
        bit bad;
        if (r) begin
            model_reset(i);
        end else if (m_busy[i] > 0) begin
            m_busy[i]--;
        end else if (v) begin
            bad = !(h == 2'b01 || h == 2'b10);
            m_n[i]++;
            if (bad) m_bad[i]++;
            if (bad && (!m_lock[i] || m_bad[i] == 16)) begin
                m_lock[i] = 1'b0;
                m_busy[i] = m_high[i] + LOW_CYC;
                m_n[i]    = 0;
                m_bad[i]  = 0;
            end else if (m_n[i] == 64) begin
                if (m_bad[i] == 0) m_lock[i] = 1'b1;
                m_n[i]   = 0;
                m_bad[i] = 0;
            end
        end
    endtask

    function automatic logic exp_slip(input int i);
        return m_busy[i] > LOW_CYC;
    endfunction

    function automatic logic [1:0] rnd_good();
        return ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] rnd_bad();
        return ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
    endfunction

    // Drive one clock of input, advance the model at the edge, check 1 after.
    task automatic cycle(input logic [1:0] h, input logic v);
        hdr = h;
        hv  = v;
        @(posedge clk);
        model_step(0, h, v, rst0);
        model_step(1, h, v, rst1);
        #1;
        chk("dut0_lock", lock0, m_lock[0]);
        chk("dut0_slip", slip0, exp_slip(0));
        chk("dut4_lock", lock1, m_lock[1]);
        chk("dut4_slip", slip1, exp_slip(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt0, cnt1, sent, guard, bad_left, seg_rate;
        bit make_bad;

        m_high[0] = 1;
        m_high[1] = 4;
        model_reset(0);
        model_reset(1);
        rst0 = 1'b1;
        rst1 = 1'b1;
        hdr  = 2'b00;
        hv   = 1'b0;

        // Reset state; headers offered under reset must not count.
        repeat (3) cycle(rnd_good(), 1'b1);
        chk("reset_lock0", lock0, 1'b0);
        chk("reset_slip0", slip0, 1'b0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // 64 clean headers back to back: lock one clock after the 64th.
        repeat (63) cycle(rnd_good(), 1'b1);
        chk("lock_after_63", lock0, 1'b0);
        cycle(rnd_good(), 1'b1);
        chk("lock_after_64_dut0", lock0, 1'b1);
        chk("lock_after_64_dut4", lock1, 1'b1);

        // Locked window with exactly 15 bad headers at random places.
        bad_left = 15;
        for (int k = 0; k < 64; k++) begin
            make_bad = (bad_left > 0) && ($urandom_range(0, 63 - k) < bad_left);
            if (make_bad) bad_left--;
            cycle(make_bad ? rnd_bad() : rnd_good(), 1'b1);
        end
        chk("lock_held_15_bad", lock0, 1'b1);
        chk("no_slip_15_bad", slip0, 1'b0);
        repeat (64) cycle(rnd_good(), 1'b1);
        chk("lock_held_clean_window", lock0, 1'b1);

        // Locked window reaching 16 bad headers: lock falls, slip rises.
        bad_left = 16;
        for (int k = 0; k < 40 && bad_left > 0; k++) begin
            make_bad = ($urandom_range(0, 39 - k) < bad_left);
            if (make_bad && bad_left == 1) chk("lock_before_16th", lock0, 1'b1);
            if (make_bad) bad_left--;
            cycle(make_bad ? rnd_bad() : rnd_good(), 1'b1);
        end
        chk("lock_after_16th", lock0, 1'b0);
        chk("slip_after_16th", slip0, 1'b1);

        // Headers during the slip are ignored, whatever their qualifier.
        repeat (9) cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        repeat (4) cycle(rnd_bad(), 1'b0);

        // Unlocked, a single 2'b11: pulse widths 1 and 4 within the slip.
        cycle(2'b11, 1'b1);
        chk("slip_first_clock", slip0, 1'b1);
        cnt0 = int'(slip0);
        cnt1 = int'(slip1);
        repeat (8) begin
            cycle(2'($urandom_range(0, 3)), 1'b1);
            cnt0 += int'(slip0);
            cnt1 += int'(slip1);
        end
        repeat (4) begin
            cycle(rnd_bad(), 1'b0);
            cnt0 += int'(slip0);
            cnt1 += int'(slip1);
        end
        chk_int("slip_width_dut0", cnt0, 1);
        chk_int("slip_width_dut4", cnt1, 4);

        // Count restarts after the slip.
        repeat (63) cycle(rnd_good(), 1'b1);
        chk("relock_after_63", lock0, 1'b0);
        cycle(rnd_good(), 1'b1);
        chk("relock_after_64", lock0, 1'b1);

        // Reset both asynchronously, then 64 headers with a random qualifier.
        rst0 = 1'b1;
        rst1 = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        chk("async_rst_lock0", lock0, 1'b0);
        cycle(rnd_good(), 1'b1);
        rst0 = 1'b0;
        rst1 = 1'b0;
        sent  = 0;
        guard = 0;
        while (sent < 64 && guard < 2000) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            cycle(v ? rnd_good() : 2'($urandom_range(0, 3)), v);
            if (v) sent++;
            guard++;
            if (sent == 63 && v) chk("toggle_lock_after_63", lock0, 1'b0);
        end
        chk_int("toggle_headers_sent", sent, 64);
        chk("toggle_lock_after_64", lock0, 1'b1);

        // dut4: unlock by reset, force a slip, reset in the middle of the pulse.
        rst1 = 1'b1;
        model_reset(1);
        cycle(rnd_good(), 1'b0);
        rst1 = 1'b0;
        cycle(rnd_bad(), 1'b1);
        chk("dut4_slip_started", slip1, 1'b1);
        cycle(rnd_good(), 1'b0);
        chk("dut4_slip_still_high", slip1, 1'b1);
        #2;
        rst1 = 1'b1;
        model_reset(1);
        #1;
        chk("dut4_async_slip_drop", slip1, 1'b0);
        cycle(rnd_good(), 1'b0);
        rst1 = 1'b0;
        repeat (64) cycle(rnd_good(), 1'b1);
        chk("dut4_lock_after_reset", lock1, 1'b1);

        // Random traffic in segments with different error rates.
        for (int seg = 0; seg < 6; seg++) begin
            case (seg % 3)
                0: seg_rate = 0;
                1: seg_rate = 60;
                default: seg_rate = 6;
            endcase
            repeat (500) begin
                logic v;
                logic [1:0] h;
                v = ($urandom_range(0, 3) != 0);
                if (seg_rate != 0 && $urandom_range(0, seg_rate - 1) == 0)
                    h = rnd_bad();
                else
                    h = rnd_good();
                cycle(h, v);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/taxi_baser_rx_block_lock.md
TAXI_BASER_RX_BLOCK_LOCK -- requirements
Module: taxi_baser_rx_block_lock

Interface
REQ-001 SHALL have parameter HDR_W, default 2, sync header width; elaboration SHALL fail with $fatal if not 2.
REQ-002 SHALL have parameter BITSLIP_HIGH_CYCLES, default 1, bitslip pulse width in clocks; elaboration SHALL fail if < 1.
REQ-003 SHALL have parameter BITSLIP_LOW_CYCLES, default 8, settle time after a slip in clocks; elaboration SHALL fail if < 1.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port encoded_rx_hdr  input  HDR_W  sync header from gearbox, aligned with the decoder input.
REQ-007 SHALL have port encoded_rx_hdr_valid  input  1  qualifies encoded_rx_hdr; header sampled only when high.
REQ-008 SHALL have port serdes_rx_bitslip  output  1  registered request to the SERDES/gearbox to shift alignment by one bit.
REQ-009 SHALL have port rx_block_lock  output  1  registered block-lock status.

Function
REQ-010 Header valid SHALL mean encoded_rx_hdr == 2'b01 or 2'b10; 2'b00 and 2'b11 SHALL be invalid.
REQ-011 FSM SHALL have states TEST, SLIP_HIGH, SLIP_WAIT; counters sh_cnt (7 bit, 0..63) and sh_invalid_cnt (5 bit, 0..15).
REQ-012 In TEST, cycles with encoded_rx_hdr_valid low SHALL leave all state, counters and outputs unchanged.
REQ-013 In TEST, a sampled valid header SHALL increment sh_cnt.
REQ-014 In TEST, a sampled invalid header SHALL increment sh_cnt and sh_invalid_cnt.
REQ-015 If a sampled invalid header occurs with rx_block_lock low, or makes sh_invalid_cnt reach 16, the FSM SHALL enter SLIP_HIGH next cycle: rx_block_lock 0, serdes_rx_bitslip 1, both counters cleared.
REQ-016 Otherwise, when the sampled header is the 64th of a window (sh_cnt == 63 before the increment), both counters SHALL clear next cycle.
REQ-017 If the 64th header of a window is valid and sh_invalid_cnt == 0, rx_block_lock SHALL go high on the next cycle.
REQ-018 If a window completes with 1..15 invalid headers, rx_block_lock SHALL stay high and no slip SHALL occur.
REQ-019 serdes_rx_bitslip SHALL be high for exactly BITSLIP_HIGH_CYCLES cycles in SLIP_HIGH; the FSM SHALL then enter SLIP_WAIT.
REQ-020 In SLIP_WAIT, serdes_rx_bitslip SHALL be low for exactly BITSLIP_LOW_CYCLES cycles; the FSM SHALL then return to TEST with counters at 0.
REQ-021 In SLIP_HIGH and SLIP_WAIT, headers SHALL be ignored whatever the value of encoded_rx_hdr_valid.
REQ-022 Latency from sampled header to output change SHALL be exactly one clock.
REQ-023 A single slip-cycle counter SHALL be used; its width SHALL be clog2(max(BITSLIP_HIGH_CYCLES, BITSLIP_LOW_CYCLES)+1).

Reset
REQ-024 rst high SHALL asynchronously set state TEST, both counters 0, the slip counter 0, serdes_rx_bitslip 0 and rx_block_lock 0.
REQ-025 Reset asserted mid-slip SHALL drop serdes_rx_bitslip immediately, without waiting for a clock edge.
REQ-026 After reset deassertion, the first sampled header SHALL be counted as header 1 of a new window.

Structure
REQ-027 SYNC_DATA (2'b10) and SYNC_CTRL (2'b01) SHALL live in shared package taxi_baser_pkg, used by this block and the BASE-R encoder and decoder.
REQ-028 The block SHALL be a single flat module with no sub-modules; the FSM state SHALL be an enum local to the module.

Verification
REQ-029 Reset, then 64 valid headers with hdr_valid high every cycle -> rx_block_lock rises 1 clock after the 64th header; serdes_rx_bitslip stays 0.
REQ-030 Unlocked, one 2'b11 header -> serdes_rx_bitslip high exactly 1 clock, then low 8 clocks with headers ignored; the 64-valid count restarts afterwards.
REQ-031 Locked, 15 invalid headers spread within one 64-header window -> lock held, no bitslip; the next window is all valid -> lock held.
REQ-032 Locked, 16 invalid headers within one window -> rx_block_lock falls and serdes_rx_bitslip rises in the same clock, 1 clock after the 16th invalid header.
REQ-033 hdr_valid toggled 50% while sending 64 valid headers -> lock after the 64th sampled header, not the 64th clock.
REQ-034 rst asserted during SLIP_HIGH with BITSLIP_HIGH_CYCLES=4 -> bitslip 0 asynchronously; after release, 64 valid headers -> lock.
